// File: rtl/nmr_acq_capture.sv
// ============================================================================
//  Module   : nmr_acq_capture
//  Purpose  : NMR echo acquisition. Strobes ADC samples inside acquisition
//             windows and pushes {SOE, sample} words into a
//             first-word-fall-through FIFO. Also keeps per-scan echo and
//             sample counters and a sticky overflow flag.
//  Options  : define NMR_ACQ_DROP_CNT_EN to add the 16-bit saturating
//             DROP_CNT output (dropped-sample counter).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nmr_acq_capture #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_AW    = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FSMSTAT,
    input  logic                  ACQ_WND,
    input  logic                  ADC_CLK,
    input  logic [DATA_WIDTH-1:0] ADC_DATA,
    input  logic                  CLEAR,
    output logic [DATA_WIDTH:0]   M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [FIFO_AW:0]      FIFO_LEVEL,
    output logic [CNT_WIDTH-1:0]  ECHO_CNT,
    output logic [CNT_WIDTH-1:0]  SAMPLE_CNT,
    output logic                  OVERFLOW,
    output logic                  BUSY
`ifdef NMR_ACQ_DROP_CNT_EN
    ,
    output logic [15:0]           DROP_CNT
`endif
);

    localparam int                 c_DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   c_LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   c_LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] c_PTR_ONE  = FIFO_AW'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WIN  = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_adc_clk_d;
    logic                   r_fsmstat_d;
    logic                   r_acq_wnd_d;
    logic                   r_soe_pend;
    logic [CNT_WIDTH-1:0]   r_echo_cnt;
    logic [CNT_WIDTH-1:0]   r_sample_cnt;
    logic [FIFO_AW-1:0]     r_wr_ptr;
    logic [FIFO_AW-1:0]     r_rd_ptr;
    logic [FIFO_AW:0]       r_level;
    logic                   r_overflow;
    logic [DATA_WIDTH:0]    r_mem [0:c_DEPTH-1];

    logic                   w_strobe;
    logic                   w_fsm_rise;
    logic                   w_wnd_rise;
    logic                   w_wnd_fall;
    logic                   w_win_open;
    logic                   w_win_strobe;
    logic                   w_full;
    logic                   w_valid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;

    // ADC_CLK runs at CLK/4, so its rising edge gives one strobe per 4 CLK.
    assign w_strobe     = ADC_CLK & ~r_adc_clk_d;
    assign w_fsm_rise   = FSMSTAT & ~r_fsmstat_d;
    assign w_wnd_rise   = ACQ_WND & ~r_acq_wnd_d;
    assign w_wnd_fall   = ~ACQ_WND & r_acq_wnd_d;
    // A window only opens while the sequencer is still busy; losing FSMSTAT wins.
    assign w_win_open   = (r_state == S_RUN) & FSMSTAT & w_wnd_rise;
    assign w_win_strobe = w_strobe & (r_state == S_WIN);

    // Full is judged on the pre-pop level, so a same-cycle pop never frees room.
    assign w_full  = (r_level == c_LVL_FULL);
    assign w_valid = (r_level != '0);
    assign w_push  = w_win_strobe & ~w_full & ~CLEAR;
    assign w_drop  = w_win_strobe & w_full;
    assign w_pop   = w_valid & M_READY & ~CLEAR;

    // Register input copies for edge detection.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_adc_clk_d <= 1'b0;
            r_fsmstat_d <= 1'b0;
            r_acq_wnd_d <= 1'b0;
        end else begin
            r_adc_clk_d <= ADC_CLK;
            r_fsmstat_d <= FSMSTAT;
            r_acq_wnd_d <= ACQ_WND;
        end
    end

    // Scan/window state machine with registered BUSY and per-scan counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_echo_cnt   <= '0;
            r_sample_cnt <= '0;
        end else begin
            if (w_win_strobe) begin
                r_sample_cnt <= r_sample_cnt + c_CNT_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fsm_rise) begin
                        r_state      <= S_RUN;
                        r_busy       <= 1'b1;
                        r_echo_cnt   <= '0;
                        r_sample_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (!FSMSTAT) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_win_open) begin
                        r_state    <= S_WIN;
                        r_echo_cnt <= r_echo_cnt + c_CNT_ONE;
                    end
                end
                S_WIN: begin
                    if (!FSMSTAT) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_wnd_fall) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // SOE pending: armed when a window opens, consumed only by a stored word.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_soe_pend <= 1'b0;
        end else if (w_win_open) begin
            r_soe_pend <= 1'b1;
        end else if (w_push) begin
            r_soe_pend <= 1'b0;
        end
    end

    // FIFO pointers, level and sticky overflow; CLEAR flushes everything.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (CLEAR) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Sample storage; no reset so it maps onto RAM.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_soe_pend, ADC_DATA};
        end
    end

    // Fall-through head; forced to zero when empty so reset shows M_DATA=0.
    always_comb begin
        M_DATA = '0;
        if (w_valid) begin
            M_DATA = r_mem[r_rd_ptr];
        end
    end

`ifdef NMR_ACQ_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of samples lost to a full FIFO.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_drop_cnt <= 16'd0;
        end else if (CLEAR) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign DROP_CNT = r_drop_cnt;
`endif

    assign M_VALID    = w_valid;
    assign FIFO_LEVEL = r_level;
    assign ECHO_CNT   = r_echo_cnt;
    assign SAMPLE_CNT = r_sample_cnt;
    assign OVERFLOW   = r_overflow;
    assign BUSY       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_nmr_acq_capture.sv
// ============================================================================
//  Module   : tb_nmr_acq_capture
//  Purpose  : Self-checking bench for nmr_acq_capture (FIFO_AW=3, depth 8).
//             A reference model fills a scoreboard queue with expected FIFO
//             words; every pop is compared against the queue head.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nmr_acq_capture;

    localparam int DW    = 14;
    localparam int AW    = 3;
    localparam int CW    = 32;
    localparam int DEPTH = 8;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_WIN  = 2;

    logic          CLK      = 1'b0;
    logic          RESET    = 1'b1;
    logic          FSMSTAT  = 1'b0;
    logic          ACQ_WND  = 1'b0;
    logic          ADC_CLK  = 1'b0;
    logic [DW-1:0] ADC_DATA = '0;
    logic          CLEAR    = 1'b0;
    logic          M_READY  = 1'b0;
    logic [DW:0]   M_DATA;
    logic          M_VALID;
    logic [AW:0]   FIFO_LEVEL;
    logic [CW-1:0] ECHO_CNT;
    logic [CW-1:0] SAMPLE_CNT;
    logic          OVERFLOW;
    logic          BUSY;
`ifdef NMR_ACQ_DROP_CNT_EN
    logic [15:0]   DROP_CNT;
`endif

    int errors = 0;
    int checks = 0;
    int adc_ph = 0;

    // reference model state
    int          m_state = M_IDLE;
    logic        m_adc_d = 1'b0;
    logic        m_fsm_d = 1'b0;
    logic        m_wnd_d = 1'b0;
    logic        m_soe   = 1'b0;
    logic [DW:0] sb_q[$];
    bit          rx_soe[$];

    nmr_acq_capture #(
        .DATA_WIDTH (DW),
        .FIFO_AW    (AW),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FSMSTAT    (FSMSTAT),
        .ACQ_WND    (ACQ_WND),
        .ADC_CLK    (ADC_CLK),
        .ADC_DATA   (ADC_DATA),
        .CLEAR      (CLEAR),
        .M_DATA     (M_DATA),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .FIFO_LEVEL (FIFO_LEVEL),
        .ECHO_CNT   (ECHO_CNT),
        .SAMPLE_CNT (SAMPLE_CNT),
        .OVERFLOW   (OVERFLOW),
        .BUSY       (BUSY)
`ifdef NMR_ACQ_DROP_CNT_EN
        ,
        .DROP_CNT   (DROP_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // ADC clock at CLK/4 plus a ramp on the data bus, updated 1 ns after each edge.
    initial forever begin
        @(posedge CLK);
        #1;
        adc_ph   = (adc_ph + 1) % 4;
        ADC_CLK  = adc_ph[1];
        ADC_DATA = ADC_DATA + 14'd1;
    end

    // Reference model + scoreboard, evaluated mid-cycle with the inputs the next edge will see.
    initial forever begin
        logic        strobe;
        logic        full;
        logic [DW:0] exp_w;
        @(negedge CLK);
        if (RESET) begin
            sb_q.delete();
            m_state = M_IDLE;
            m_adc_d = 1'b0;
            m_fsm_d = 1'b0;
            m_wnd_d = 1'b0;
            m_soe   = 1'b0;
        end else begin
            strobe = ADC_CLK && !m_adc_d;
            full   = (sb_q.size() == DEPTH);
            if (!CLEAR && M_READY) begin
                if (sb_q.size() != 0) begin
                    exp_w = sb_q.pop_front();
                    checks++;
                    if (M_VALID !== 1'b1 || M_DATA !== exp_w) begin
                        errors++;
                        $display("FAIL fifo_head: got valid=%b data=%h, want valid=1 data=%h", M_VALID, M_DATA, exp_w);
                    end
                    rx_soe.push_back(M_DATA[DW]);
                end else begin
                    checks++;
                    if (M_VALID !== 1'b0) begin
                        errors++;
                        $display("FAIL fifo_empty_valid: got valid=%b data=%h, want valid=0", M_VALID, M_DATA);
                    end
                end
            end
            if (CLEAR) begin
                sb_q.delete();
            end else if (m_state == M_WIN && strobe && !full) begin
                sb_q.push_back({m_soe, ADC_DATA});
                m_soe = 1'b0;
            end
            case (m_state)
                M_IDLE: if (FSMSTAT && !m_fsm_d) m_state = M_RUN;
                M_RUN: begin
                    if (!FSMSTAT) m_state = M_IDLE;
                    else if (ACQ_WND && !m_wnd_d) begin
                        m_state = M_WIN;
                        m_soe   = 1'b1;
                    end
                end
                default: begin
                    if (!FSMSTAT) m_state = M_IDLE;
                    else if (!ACQ_WND && m_wnd_d) m_state = M_RUN;
                end
            endcase
            m_adc_d = ADC_CLK;
            m_fsm_d = FSMSTAT;
            m_wnd_d = ACQ_WND;
        end
    end

    // Advance n clocks, leaving time 2 ns after the last edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (M_DATA !== '0)     begin errors++; $display("FAIL reset_m_data: got %h want 0", M_DATA); end
        checks++; if (M_VALID !== 1'b0)  begin errors++; $display("FAIL reset_m_valid: got %b want 0", M_VALID); end
        checks++; if (FIFO_LEVEL !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", FIFO_LEVEL); end
        checks++; if (ECHO_CNT !== '0)   begin errors++; $display("FAIL reset_echo: got %0d want 0", ECHO_CNT); end
        checks++; if (SAMPLE_CNT !== '0) begin errors++; $display("FAIL reset_sample: got %0d want 0", SAMPLE_CNT); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", OVERFLOW); end
        checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        cycles(3);
        RESET = 1'b0;
        cycles(2);
    endtask

    task automatic test_single_window();
        bit s0;
        bit s1;
        rx_soe.delete();
        M_READY = 1'b1;
        FSMSTAT = 1'b1;
        cycles(3);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy_run: got %b want 1", BUSY); end
        ACQ_WND = 1'b1;
        cycles(40);
        ACQ_WND = 1'b0;
        cycles(6);
        FSMSTAT = 1'b0;
        cycles(3);
        s0 = (rx_soe.size() > 0) ? rx_soe[0] : 1'b0;
        s1 = (rx_soe.size() > 1) ? rx_soe[1] : 1'b1;
        checks++; if (rx_soe.size() != 10) begin errors++; $display("FAIL single_words: got %0d want 10", rx_soe.size()); end
        checks++; if (s0 !== 1'b1)         begin errors++; $display("FAIL single_soe_first: got %b want 1", s0); end
        checks++; if (s1 !== 1'b0)         begin errors++; $display("FAIL single_soe_second: got %b want 0", s1); end
        checks++; if (ECHO_CNT !== 32'd1)  begin errors++; $display("FAIL single_echo: got %0d want 1", ECHO_CNT); end
        checks++; if (SAMPLE_CNT !== 32'd10) begin errors++; $display("FAIL single_sample: got %0d want 10", SAMPLE_CNT); end
        checks++; if (OVERFLOW !== 1'b0)   begin errors++; $display("FAIL single_overflow: got %b want 0", OVERFLOW); end
        checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL single_busy_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_multi_window();
        bit s;
        rx_soe.delete();
        M_READY = 1'b1;
        FSMSTAT = 1'b1;
        cycles(3);
        checks++; if (ECHO_CNT !== 32'd0)   begin errors++; $display("FAIL multi_echo_zero: got %0d want 0", ECHO_CNT); end
        checks++; if (SAMPLE_CNT !== 32'd0) begin errors++; $display("FAIL multi_sample_zero: got %0d want 0", SAMPLE_CNT); end
        for (int w = 0; w < 3; w++) begin
            ACQ_WND = 1'b1;
            cycles(16);
            ACQ_WND = 1'b0;
            cycles(6);
        end
        FSMSTAT = 1'b0;
        cycles(3);
        checks++; if (rx_soe.size() != 12) begin errors++; $display("FAIL multi_words: got %0d want 12", rx_soe.size()); end
        for (int i = 0; i < 12; i++) begin
            s = (i < rx_soe.size()) ? rx_soe[i] : 1'b0;
            checks++;
            if (s !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL multi_soe[%0d]: got %b want %b", i, s, ((i % 4) == 0));
            end
        end
        checks++; if (ECHO_CNT !== 32'd3)   begin errors++; $display("FAIL multi_echo: got %0d want 3", ECHO_CNT); end
        checks++; if (SAMPLE_CNT !== 32'd12) begin errors++; $display("FAIL multi_sample: got %0d want 12", SAMPLE_CNT); end
    endtask

    task automatic test_overflow();
        rx_soe.delete();
        M_READY = 1'b0;
        FSMSTAT = 1'b1;
        cycles(3);
        ACQ_WND = 1'b1;
        cycles(40);
        ACQ_WND = 1'b0;
        cycles(3);
        checks++; if (FIFO_LEVEL !== 4'd8)  begin errors++; $display("FAIL ovf_level: got %0d want 8", FIFO_LEVEL); end
        checks++; if (OVERFLOW !== 1'b1)    begin errors++; $display("FAIL ovf_flag: got %b want 1", OVERFLOW); end
        checks++; if (SAMPLE_CNT !== 32'd10) begin errors++; $display("FAIL ovf_sample: got %0d want 10", SAMPLE_CNT); end
        checks++; if (M_VALID !== 1'b1)     begin errors++; $display("FAIL ovf_valid: got %b want 1", M_VALID); end
`ifdef NMR_ACQ_DROP_CNT_EN
        checks++; if (DROP_CNT !== 16'd2)   begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 2", DROP_CNT); end
`endif
    endtask

    task automatic test_clear_full();
        int n;
        ACQ_WND = 1'b1;
        cycles(3);
        n = 0;
        while (adc_ph != 2 && n < 8) begin
            cycles(1);
            n++;
        end
        checks++; if (n >= 8) begin errors++; $display("FAIL clear_strobe_wait: got timeout want strobe phase"); end
        CLEAR = 1'b1;
        cycles(1);
        CLEAR = 1'b0;
        checks++; if (FIFO_LEVEL !== '0)  begin errors++; $display("FAIL clear_level: got %0d want 0", FIFO_LEVEL); end
        checks++; if (OVERFLOW !== 1'b0)  begin errors++; $display("FAIL clear_overflow: got %b want 0", OVERFLOW); end
        checks++; if (M_VALID !== 1'b0)   begin errors++; $display("FAIL clear_valid: got %b want 0", M_VALID); end
        checks++; if (BUSY !== 1'b1)      begin errors++; $display("FAIL clear_busy: got %b want 1", BUSY); end
        checks++; if (ECHO_CNT !== 32'd2) begin errors++; $display("FAIL clear_echo: got %0d want 2", ECHO_CNT); end
`ifdef NMR_ACQ_DROP_CNT_EN
        checks++; if (DROP_CNT !== 16'd0) begin errors++; $display("FAIL clear_drop_cnt: got %0d want 0", DROP_CNT); end
`endif
        n = 0;
        while (FIFO_LEVEL !== 4'd1 && n < 8) begin
            cycles(1);
            n++;
        end
        checks++; if (FIFO_LEVEL !== 4'd1) begin errors++; $display("FAIL clear_next_write: got level %0d want 1", FIFO_LEVEL); end
        checks++; if (M_DATA[DW] !== 1'b1) begin errors++; $display("FAIL clear_soe_kept: got %b want 1", M_DATA[DW]); end
        M_READY = 1'b1;
        ACQ_WND = 1'b0;
        cycles(3);
        FSMSTAT = 1'b0;
        cycles(4);
        checks++; if (FIFO_LEVEL !== '0) begin errors++; $display("FAIL clear_drain: got %0d want 0", FIFO_LEVEL); end
    endtask

    task automatic test_ready_toggle();
        M_READY = 1'b1;
        FSMSTAT = 1'b1;
        cycles(3);
        rx_soe.delete();
        ACQ_WND = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cycles(1);
            M_READY = ~M_READY;
        end
        ACQ_WND = 1'b0;
        M_READY = 1'b1;
        cycles(4);
        FSMSTAT = 1'b0;
        cycles(3);
        checks++; if (rx_soe.size() != 16) begin errors++; $display("FAIL toggle_words: got %0d want 16", rx_soe.size()); end
        checks++; if (SAMPLE_CNT !== 32'd16) begin errors++; $display("FAIL toggle_sample: got %0d want 16", SAMPLE_CNT); end
        checks++; if (OVERFLOW !== 1'b0)    begin errors++; $display("FAIL toggle_overflow: got %b want 0", OVERFLOW); end
        checks++; if (FIFO_LEVEL !== '0)    begin errors++; $display("FAIL toggle_level: got %0d want 0", FIFO_LEVEL); end
    endtask

    task automatic test_reset_mid();
        int n;
        M_READY = 1'b0;
        FSMSTAT = 1'b1;
        cycles(3);
        ACQ_WND = 1'b1;
        n = 0;
        while (FIFO_LEVEL !== 4'd5 && n < 60) begin
            cycles(1);
            n++;
        end
        checks++; if (FIFO_LEVEL !== 4'd5) begin errors++; $display("FAIL rmid_fill: got %0d want 5", FIFO_LEVEL); end
        RESET   = 1'b1;
        FSMSTAT = 1'b0;
        ACQ_WND = 1'b0;
        #1;
        checks++; if (M_DATA !== '0)     begin errors++; $display("FAIL rmid_m_data: got %h want 0", M_DATA); end
        checks++; if (M_VALID !== 1'b0)  begin errors++; $display("FAIL rmid_m_valid: got %b want 0", M_VALID); end
        checks++; if (FIFO_LEVEL !== '0) begin errors++; $display("FAIL rmid_level: got %0d want 0", FIFO_LEVEL); end
        checks++; if (ECHO_CNT !== '0)   begin errors++; $display("FAIL rmid_echo: got %0d want 0", ECHO_CNT); end
        checks++; if (SAMPLE_CNT !== '0) begin errors++; $display("FAIL rmid_sample: got %0d want 0", SAMPLE_CNT); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b want 0", OVERFLOW); end
        checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL rmid_busy: got %b want 0", BUSY); end
        cycles(2);
        RESET   = 1'b0;
        ACQ_WND = 1'b1;
        cycles(20);
        checks++; if (FIFO_LEVEL !== '0) begin errors++; $display("FAIL rmid_no_write: got %0d want 0", FIFO_LEVEL); end
        checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL rmid_idle: got %b want 0", BUSY); end
        ACQ_WND = 1'b0;
        cycles(3);
        M_READY = 1'b1;
        FSMSTAT = 1'b1;
        cycles(3);
        rx_soe.delete();
        ACQ_WND = 1'b1;
        cycles(16);
        ACQ_WND = 1'b0;
        cycles(4);
        FSMSTAT = 1'b0;
        cycles(3);
        checks++; if (rx_soe.size() != 4) begin errors++; $display("FAIL rmid_resume_words: got %0d want 4", rx_soe.size()); end
        checks++; if (ECHO_CNT !== 32'd1) begin errors++; $display("FAIL rmid_resume_echo: got %0d want 1", ECHO_CNT); end
        checks++; if (SAMPLE_CNT !== 32'd4) begin errors++; $display("FAIL rmid_resume_sample: got %0d want 4", SAMPLE_CNT); end
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_multi_window();
        test_overflow();
        test_clear_full();
        test_ready_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/nmr_acq_capture.md
NMR_ACQ_CAPTURE -- requirements
Module: nmr_acq_capture

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- DATA_WIDTH, 14, ADC sample width.
- FIFO_AW, 10, FIFO address width; depth = 2^FIFO_AW.
- CNT_WIDTH, 32, width of the echo and sample counters.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- CLK, in, 1, system clock.
- RESET, in, 1, asynchronous, active-high reset.
- FSMSTAT, in, 1, pulse-sequencer busy flag.
- ACQ_WND, in, 1, acquisition window from the pulse sequencer.
- ADC_CLK, in, 1, ADC clock (CLK/4, synchronous to CLK).
- ADC_DATA, in, DATA_WIDTH, ADC parallel output.
- CLEAR, in, 1, one-cycle FIFO flush and flag clear.
- M_DATA, out, DATA_WIDTH+1, {SOE, sample}; SOE = start-of-echo tag.
- M_VALID, out, 1, FIFO head valid.
- M_READY, in, 1, consumer accepts the head.
- FIFO_LEVEL, out, FIFO_AW+1, stored word count.
- ECHO_CNT, out, CNT_WIDTH, windows opened this scan.
- SAMPLE_CNT, out, CNT_WIDTH, strobes seen inside windows this scan.
- OVERFLOW, out, 1, sticky; a sample was dropped on full.
- BUSY, out, 1, state is not IDLE.

Function
REQ-003 The block SHALL register ADC_CLK each cycle; a sample strobe SHALL be ADC_CLK=1 with its registered copy =0 (one strobe every 4 CLK).
REQ-004 On a strobe cycle, ADC_DATA sampled at that CLK edge SHALL be the captured value.
REQ-005 The FSM SHALL have states IDLE, RUN, and WIN.
REQ-006 IDLE SHALL move to RUN on a FSMSTAT rising edge (FSMSTAT=1, previous=0).
- The same cycle SHALL zero ECHO_CNT and SAMPLE_CNT.
- OVERFLOW and FIFO contents SHALL be kept.
REQ-007 RUN SHALL move to WIN on an ACQ_WND rising edge, incrementing ECHO_CNT by 1.
- The SOE pending flag SHALL be set at that edge.
REQ-008 WIN SHALL move to RUN on an ACQ_WND falling edge.
REQ-009 RUN and WIN SHALL move to IDLE when FSMSTAT=0.
- If ACQ_WND falls in the same cycle, IDLE SHALL take priority.
REQ-010 A strobe SHALL be written to the FIFO only in state WIN; strobes in IDLE or RUN SHALL be ignored.
- An ACQ_WND rising edge coincident with a strobe SHALL NOT write that strobe (the FSM is still in RUN).
REQ-011 The first write in each window SHALL carry SOE=1; later writes in that window SHALL carry SOE=0.
- If the first strobe of a window is dropped, the SOE pending flag SHALL remain set for the next accepted write.
REQ-012 SAMPLE_CNT SHALL increment on every strobe in WIN, whether written or dropped.
REQ-013 ECHO_CNT and SAMPLE_CNT SHALL wrap modulo 2^CNT_WIDTH.
REQ-014 The FIFO SHALL be first-word-fall-through.
- A word written at edge N SHALL appear on M_DATA with M_VALID=1 after edge N+1 at the latest.
- A pop SHALL occur on any cycle with M_VALID=1 and M_READY=1.
- M_DATA SHALL hold stable while M_VALID=1 and M_READY=0.
REQ-015 Full SHALL be evaluated before any same-cycle pop.
- A strobe in WIN while FIFO_LEVEL=2^FIFO_AW SHALL be dropped and SHALL set OVERFLOW, even if a pop occurs that cycle.
REQ-016 A simultaneous write and pop SHALL leave FIFO_LEVEL unchanged; read and write pointers SHALL wrap modulo depth.
REQ-017 CLEAR=1 SHALL empty the FIFO, clear OVERFLOW, and discard any same-cycle write.
- CLEAR SHALL NOT change the state, ECHO_CNT, or SAMPLE_CNT.
REQ-018 BUSY SHALL be 1 in RUN and WIN and 0 in IDLE.

Reset
REQ-019 RESET=1 SHALL asynchronously force:
- state to IDLE and FIFO pointers to 0;
- M_VALID=0, FIFO_LEVEL=0, ECHO_CNT=0, SAMPLE_CNT=0, OVERFLOW=0, BUSY=0, M_DATA=0;
- edge-detect registers and the SOE pending flag to 0.
REQ-020 Reset asserted mid-window SHALL discard all FIFO contents.
- After release, operation SHALL resume only on a new FSMSTAT rising edge.

Configuration
REQ-021 With macro NMR_ACQ_DROP_CNT_EN defined, the block SHALL add output DROP_CNT (16 bits).
- DROP_CNT SHALL count dropped samples and saturate at 0xFFFF.
- DROP_CNT SHALL be zeroed by RESET and CLEAR.
REQ-022 Without NMR_ACQ_DROP_CNT_EN, DROP_CNT SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-023 One window of 40 CLK, ADC_DATA=ramp, M_READY=1 -> 10 words, first SOE=1, ECHO_CNT=1, SAMPLE_CNT=10, OVERFLOW=0.
REQ-024 FSMSTAT high, 3 windows of 16 CLK, M_READY=1 -> 12 words, SOE=1 on words 0, 4, 8, ECHO_CNT=3.
REQ-025 FIFO_AW=2, M_READY=0, 6 strobes in WIN -> FIFO_LEVEL=4, OVERFLOW=1, SAMPLE_CNT=6, DROP_CNT=2 (macro on).
REQ-026 M_READY toggled 1/0 each cycle during a 64-CLK window -> all 16 words delivered in order, none lost.
REQ-027 RESET pulsed mid-window with FIFO_LEVEL=5 -> all outputs 0 immediately; after release, no writes until a new FSMSTAT rising edge.
REQ-028 CLEAR on the same cycle as a strobe in WIN with the FIFO full -> FIFO_LEVEL=0, OVERFLOW=0, the strobe not stored, state still WIN.
